d_mem_arbiter: RTL and testbench
================================

D_MEM_ARBITER -- requirements
Module: d_mem_arbiter

Interface
REQ-001 Parameter d_addr_width SHALL default to 8 and set the width of every address port.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 m0_req, m1_req  input  1 each  requester N asks for a data-memory access.
REQ-005 m0_dir, m1_dir  input  1 each  access direction, encoded as in macros/direction.vh.
REQ-006 m0_addr, m1_addr  input  d_addr_width each  access address.
REQ-007 m0_wdata, m1_wdata  input  8 each  write data.
REQ-008 m0_ack, m1_ack  output  1 each  access complete or read data valid for requester N.
REQ-009 m0_rdata, m1_rdata  output  8 each  read data for requester N.
REQ-010 d_req, d_dir, d_addr, d_wdata  output  1/1/d_addr_width/8  shared data-memory request bus.
REQ-011 d_ack, d_rdata  input  1/8  shared data-memory response.
REQ-012 grant  output  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-014 In IDLE, d_req, d_dir, d_addr, d_wdata, both mN_ack, both mN_rdata and grant SHALL be 0.
REQ-015 IDLE SHALL move to GRANT0 or GRANT1 on the next edge when at least one mN_req is high; the choice SHALL follow REQ-021/REQ-022.
REQ-016 In GRANTn, d_req/d_dir/d_addr/d_wdata SHALL combinationally equal mN_req/mN_dir/mN_addr/mN_wdata; mN_ack = d_ack; mN_rdata = d_rdata; the other requester's ack and rdata SHALL be 0.
REQ-017 GRANTn SHALL return to IDLE on the edge that ends a cycle in which mN_req is low; the state machine SHALL NOT go directly from one grant state to another.
REQ-018 Every ownership change SHALL therefore include at least one cycle with d_req = 0, so the memory's registered ready flag clears and a new owner never receives a stale ack.
REQ-019 Latency SHALL be: mN_req rises in cycle t while IDLE -> d_req high in t+1 -> mN_ack high in t+2 (memory ready after one cycle).
REQ-020 If a requester drops mN_req before ack (abort), the arbiter SHALL go to IDLE without error; a write may already have been committed.
REQ-021 A register last_grant SHALL record the port of the most recent grant; if both requests are high in IDLE, the port not equal to last_grant SHALL win.
REQ-022 If only one request is high in IDLE, that port SHALL win regardless of last_grant.
REQ-023 A requester that holds mN_req high after ack SHALL keep the grant; while it holds the grant, the other requester SHALL wait with its ack at 0.

Reset
REQ-024 While rst is high, the state machine SHALL be IDLE and last_grant SHALL be 1, so m0 wins the first simultaneous request.
REQ-025 Reset asserted mid-transaction SHALL immediately force all outputs to their IDLE values (REQ-014), independently of clk.
REQ-026 After rst deasserts, the first arbitration SHALL take place on the first clock edge on which a request is sampled.

Configuration
REQ-027 Macro D_ARB_ROUND_ROBIN_EN defined: arbitration SHALL follow REQ-021.
REQ-028 Macro D_ARB_ROUND_ROBIN_EN undefined: m0 SHALL always win simultaneous requests; last_grant SHALL NOT be implemented; all other behaviour SHALL be unchanged.

Verification
REQ-029 m0 reads addr 0x05 (memory holds 0x3C) alone -> d_req at t+1, m0_ack and m0_rdata = 0x3C at t+2, m1_ack stays 0, grant = 01.
REQ-030 m1 writes 0xA5 to 0x10, then m0 reads 0x10 -> m0_rdata = 0xA5; at least one d_req = 0 cycle between the two grants.
REQ-031 m0 and m1 both request from IDLE after reset, each dropping req one cycle after its ack -> grant sequence 01, 00, 10, 00, 01 with D_ARB_ROUND_ROBIN_EN defined; always 01 when first with it undefined.
REQ-032 m0 holds req high for 10 cycles after ack while m1 requests -> m1_ack = 0 throughout; m1 is granted one IDLE cycle after m0_req falls.
REQ-033 rst pulsed while GRANT1 with d_ack high -> d_req, m1_ack and grant go to 0 in the same cycle; next simultaneous request grants m0.

Source files
------------

// File: rtl/d_mem_arbiter.sv
// Two-port arbiter in front of a single data memory. Optional round-robin
// tie-breaking is enabled with the D_ARB_ROUND_ROBIN_EN macro; otherwise m0 wins ties.
module d_mem_arbiter #(
  parameter int d_addr_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic                    m0_dir,
  input  logic [d_addr_width-1:0] m0_addr,
  input  logic [7:0]              m0_wdata,
  input  logic                    m1_req,
  input  logic                    m1_dir,
  input  logic [d_addr_width-1:0] m1_addr,
  input  logic [7:0]              m1_wdata,
  output logic                    m0_ack,
  output logic [7:0]              m0_rdata,
  output logic                    m1_ack,
  output logic [7:0]              m1_rdata,
  output logic                    d_req,
  output logic                    d_dir,
  output logic [d_addr_width-1:0] d_addr,
  output logic [7:0]              d_wdata,
  input  logic                    d_ack,
  input  logic [7:0]              d_rdata,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   prefer_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef D_ARB_ROUND_ROBIN_EN
  // Remembers the port of the most recent grant; ties go to the other port.
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && next_state == GRANT0) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && next_state == GRANT1) begin
      last_grant <= 1'b1;
    end
  end

  assign prefer_m1 = ~last_grant;
`else
  assign prefer_m1 = 1'b0;
`endif

  // Grant states always fall back through IDLE so the memory sees d_req low
  // for a cycle before any new owner takes the bus.
  always_comb begin
    next_state = state;
    d_req      = 1'b0;
    d_dir      = 1'b0;
    d_addr     = '0;
    d_wdata    = 8'h00;
    m0_ack     = 1'b0;
    m0_rdata   = 8'h00;
    m1_ack     = 1'b0;
    m1_rdata   = 8'h00;
    grant      = 2'b00;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          next_state = prefer_m1 ? GRANT1 : GRANT0;
        end else if (m0_req) begin
          next_state = GRANT0;
        end else if (m1_req) begin
          next_state = GRANT1;
        end
      end
      GRANT0: begin
        d_req    = m0_req;
        d_dir    = m0_dir;
        d_addr   = m0_addr;
        d_wdata  = m0_wdata;
        m0_ack   = d_ack;
        m0_rdata = d_rdata;
        grant    = 2'b01;
        if (!m0_req) begin
          next_state = IDLE;
        end
      end
      GRANT1: begin
        d_req    = m1_req;
        d_dir    = m1_dir;
        d_addr   = m1_addr;
        d_wdata  = m1_wdata;
        m1_ack   = d_ack;
        m1_rdata = d_rdata;
        grant    = 2'b10;
        if (!m1_req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed self-checking bench for d_mem_arbiter with a behavioural data memory
// whose ready flag is registered one cycle after d_req (dir 1 = write, 0 = read).
module tb_d_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       m0_req, m1_req;
  logic       m0_dir, m1_dir;
  logic [7:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic       d_req, d_dir;
  logic [7:0] d_addr, d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;
  logic [1:0] grant;

  int n_compared;
  int n_mismatched;

  logic [7:0] mem [256];

  d_mem_arbiter #(.d_addr_width(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_dir(m0_dir), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_dir(m1_dir), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory deliberately ignores rst so a stale ack is visible to the arbiter.
  initial begin
    d_ack   = 1'b0;
    d_rdata = 8'h00;
  end

  always @(posedge clk) begin
    d_ack   <= d_req;
    d_rdata <= mem[d_addr];
    if (d_req && d_dir) mem[d_addr] <= d_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1;
    m0_dir = 1'b0;
    m0_addr = 8'h01;
    step();
    n_compared++;
    if (grant !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_grant got %b want 00", grant);
    end
    n_compared++;
    if ({d_req, d_dir, d_addr, d_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata} !== 28'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs got %b%b %h %h %b%b %h %h want all zero",
               d_req, d_dir, d_addr, d_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata);
    end
    m0_req = 1'b0;
    m0_addr = 8'h00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    m0_req = 1'b1;
    m0_dir = 1'b0;
    m0_addr = 8'h05;
    step();
    n_compared++;
    if ({grant, d_req, d_addr} !== {2'b01, 1'b1, 8'h05}) begin
      n_mismatched++;
      $display("[TB] FAIL read_t1 got grant=%b d_req=%b d_addr=%h want 01 1 05", grant, d_req, d_addr);
    end
    n_compared++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL read_t1_ack got %b%b want 00", m0_ack, m1_ack);
    end
    step();
    n_compared++;
    if ({m0_ack, m0_rdata} !== {1'b1, 8'h3C}) begin
      n_mismatched++;
      $display("[TB] FAIL read_t2 got ack=%b rdata=%h want 1 3c", m0_ack, m0_rdata);
    end
    n_compared++;
    if ({m1_ack, m1_rdata} !== 9'h0) begin
      n_mismatched++;
      $display("[TB] FAIL read_other got ack=%b rdata=%h want 0 00", m1_ack, m1_rdata);
    end
    m0_req = 1'b0;
    step();
    n_compared++;
    if ({grant, d_req} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL read_release got grant=%b d_req=%b want 00 0", grant, d_req);
    end
  endtask

  task automatic test_write_then_read();
    m1_req = 1'b1;
    m1_dir = 1'b1;
    m1_addr = 8'h10;
    m1_wdata = 8'hA5;
    step();
    n_compared++;
    if ({grant, d_req, d_dir, d_addr, d_wdata} !== {2'b10, 1'b1, 1'b1, 8'h10, 8'hA5}) begin
      n_mismatched++;
      $display("[TB] FAIL write_bus got grant=%b req=%b dir=%b addr=%h wdata=%h want 10 1 1 10 a5",
               grant, d_req, d_dir, d_addr, d_wdata);
    end
    step();
    n_compared++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL write_ack got m1=%b m0=%b want 1 0", m1_ack, m0_ack);
    end
    m1_req = 1'b0;
    m1_dir = 1'b0;
    m0_req = 1'b1;
    m0_dir = 1'b0;
    m0_addr = 8'h10;
    step();
    n_compared++;
    if ({grant, d_req} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL handover_gap got grant=%b d_req=%b want 00 0", grant, d_req);
    end
    step();
    n_compared++;
    if ({grant, m0_ack} !== 3'b010) begin
      n_mismatched++;
      $display("[TB] FAIL reread_grant got grant=%b ack=%b want 01 0", grant, m0_ack);
    end
    step();
    n_compared++;
    if ({m0_ack, m0_rdata} !== {1'b1, 8'hA5}) begin
      n_mismatched++;
      $display("[TB] FAIL reread_data got ack=%b rdata=%h want 1 a5", m0_ack, m0_rdata);
    end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_req = 1'b1;
    m0_addr = 8'h01;
    m1_req = 1'b1;
    m1_addr = 8'h02;
    step();
    n_compared++;
    if (grant !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL tie_first got %b want 01", grant);
    end
    step();
    n_compared++;
    if ({m0_ack, m1_ack} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL tie_first_ack got %b%b want 10", m0_ack, m1_ack);
    end
    m0_req = 1'b0;
    step();
    n_compared++;
    if ({grant, d_req} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL tie_gap1 got grant=%b d_req=%b want 00 0", grant, d_req);
    end
    m0_req = 1'b1;
    step();
`ifdef D_ARB_ROUND_ROBIN_EN
    n_compared++;
    if (grant !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL tie_second got %b want 10", grant);
    end
    step();
    m1_req = 1'b0;
    step();
    n_compared++;
    if (grant !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL tie_gap2 got %b want 00", grant);
    end
    step();
    n_compared++;
    if (grant !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL tie_third got %b want 01", grant);
    end
`else
    n_compared++;
    if (grant !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL tie_second got %b want 01", grant);
    end
    step();
    m0_req = 1'b0;
    step();
    n_compared++;
    if (grant !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL tie_gap2 got %b want 00", grant);
    end
    step();
    n_compared++;
    if (grant !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL tie_third got %b want 10", grant);
    end
`endif
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_hold();
    m0_req = 1'b1;
    m0_addr = 8'h05;
    step();
    m1_req = 1'b1;
    m1_addr = 8'h10;
    step();
    n_compared++;
    if (m0_ack !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL hold_ack got %b want 1", m0_ack);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_compared++;
      if ({grant, m1_ack} !== 3'b010) begin
        n_mismatched++;
        $display("[TB] FAIL hold_wait[%0d] got grant=%b m1_ack=%b want 01 0", i, grant, m1_ack);
      end
    end
    m0_req = 1'b0;
    step();
    n_compared++;
    if ({grant, m1_ack} !== 3'b000) begin
      n_mismatched++;
      $display("[TB] FAIL hold_gap got grant=%b m1_ack=%b want 00 0", grant, m1_ack);
    end
    step();
    n_compared++;
    if (grant !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL hold_next got %b want 10", grant);
    end
    step();
    n_compared++;
    if ({m1_ack, m1_rdata} !== {1'b1, 8'hA5}) begin
      n_mismatched++;
      $display("[TB] FAIL hold_next_data got ack=%b rdata=%h want 1 a5", m1_ack, m1_rdata);
    end
  endtask

  task automatic test_reset_mid();
    // m1 still owns the bus with d_ack high from the previous task.
    #2;
    rst = 1'b1;
    #1;
    n_compared++;
    if ({d_req, m1_ack, grant} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset got d_req=%b m1_ack=%b grant=%b want 0 0 00 (d_ack=%b)",
               d_req, m1_ack, grant, d_ack);
    end
    m1_req = 1'b0;
    step();
    rst = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    step();
    n_compared++;
    if (grant !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_tie got %b want 01", grant);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h3C;
    rst = 1'b1;
    m0_req = 1'b0; m0_dir = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_dir = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
    test_reset();
    test_read();
    test_write_then_read();
    test_round_robin();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
